// File: rtl/ldm_stm_seq_pkg.sv
// Shared types and constants for the LDM/STM block-transfer sequencer.
// Imported by the sequencer top and its helpers.
package ldm_stm_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_XFER,
    S_WBACK,
    S_DONE
  } state_t;

  localparam logic [3:0] PC_CODE    = 4'hF;
  localparam int         WORD_BYTES = 4;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) begin
      c = c + {4'd0, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/ldm_stm_seq_lsb_enc16.sv
// Lowest-set-bit priority encoder over a 16-bit register list.
// Gives the index of the lowest set bit and whether any bit is set.
module lsb_enc16 (
  input  logic [15:0] vec,
  output logic [3:0]  idx,
  output logic        valid
);

  always_comb begin
    idx = '0;
    for (int i = 15; i >= 0; i--) begin
      if (vec[i]) idx = i[3:0];
    end
  end

  assign valid = |vec;

endmodule

// File: rtl/ldm_stm_seq.sv
// ARMv4 LDM/STM sequencer: walks the register list lowest-first,
// one word per memory handshake, then writes the base back.
module ldm_stm_seq
  import ldm_stm_seq_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              i_start,
  input  logic [15:0]       i_reglist,
  input  logic [3:0]        i_rn_code,
  input  logic [ADDR_W-1:0] i_base,
  input  logic              i_pre,
  input  logic              i_up,
  input  logic              i_wb,
  input  logic              i_load,
  output logic              o_busy,
  output logic              o_done,
  output logic [3:0]        o_re_code,
  input  logic [ADDR_W-1:0] i_re_reg,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [ADDR_W-1:0] o_mem_wdata,
  input  logic              i_mem_ack,
  input  logic [ADDR_W-1:0] i_mem_rdata,
  output logic              o_rd_en_wb,
  output logic [3:0]        o_rd_code_wb,
  output logic [ADDR_W-1:0] o_rd_reg_wb,
  output logic              o_rd_en_ex,
  output logic [3:0]        o_rd_code_ex,
  output logic [ADDR_W-1:0] o_rd_reg_ex
);

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(WORD_BYTES);

  state_t            state_q, state_d;
  logic [15:0]       list_q, list_clr;
  logic [ADDR_W-1:0] addr_q, wbval_q;
  logic [3:0]        rn_q;
  logic              load_q, wben_q;
  logic              wb_en_q;
  logic [3:0]        wb_code_q;
  logic [ADDR_W-1:0] wb_reg_q;

  logic [3:0]        cur;
  logic              cur_vld;
  logic              xfer, start;
  logic [ADDR_W-1:0] n4, start_addr, wb_val;

  lsb_enc16 u_enc (
    .vec   (list_q),
    .idx   (cur),
    .valid (cur_vld)
  );

  assign xfer     = (state_q == S_XFER) && cur_vld;
  assign start    = (state_q == S_IDLE) && i_start;
  assign list_clr = list_q & ~(16'd1 << cur);
  assign n4       = ADDR_W'(popcount16(i_reglist)) << 2;
  assign wb_val   = i_up ? i_base + n4 : i_base - n4;

  // lowest register always lands at the lowest address
  always_comb begin
    start_addr = i_base;
    unique case ({i_pre, i_up})
      2'b01: start_addr = i_base;
      2'b11: start_addr = i_base + STEP;
      2'b00: start_addr = i_base - n4 + STEP;
      2'b10: start_addr = i_base - n4;
      default: start_addr = i_base;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (en) begin
      unique case (state_q)
        S_IDLE:
          if (i_start) state_d = (|i_reglist) ? S_XFER : S_DONE;
        S_XFER:
          if (i_mem_ack && !(|list_clr))
            state_d = wben_q ? S_WBACK : S_DONE;
        S_WBACK: state_d = S_DONE;
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      list_q    <= '0;
      addr_q    <= '0;
      wbval_q   <= '0;
      rn_q      <= '0;
      load_q    <= 1'b0;
      wben_q    <= 1'b0;
      wb_en_q   <= 1'b0;
      wb_code_q <= '0;
      wb_reg_q  <= '0;
    end else if (en) begin
      wb_en_q <= 1'b0;
      if (start) begin
        list_q  <= i_reglist;
        addr_q  <= start_addr;
        wbval_q <= wb_val;
        rn_q    <= i_rn_code;
        load_q  <= i_load;
        // a loaded base overrides the writeback
        wben_q  <= i_wb & ~(i_load & i_reglist[i_rn_code]);
      end
      if (xfer && i_mem_ack) begin
        list_q <= list_clr;
        addr_q <= addr_q + STEP;
        if (load_q) begin
          wb_en_q   <= 1'b1;
          wb_code_q <= cur;
          wb_reg_q  <= i_mem_rdata;
        end
      end
    end
  end

  assign o_busy       = (state_q != S_IDLE);
  assign o_done       = (state_q == S_DONE);
  assign o_mem_req    = xfer & en;
  assign o_mem_we     = xfer & ~load_q;
  assign o_mem_addr   = addr_q;
  assign o_re_code    = xfer ? cur : 4'd0;
  assign o_mem_wdata  = (xfer && !load_q) ? i_re_reg : '0;
  assign o_rd_en_wb   = wb_en_q;
  assign o_rd_code_wb = wb_code_q;
  assign o_rd_reg_wb  = wb_reg_q;
  assign o_rd_en_ex   = (state_q == S_WBACK);
  assign o_rd_code_ex = o_rd_en_ex ? rn_q : 4'd0;
  assign o_rd_reg_ex  = o_rd_en_ex ? wbval_q : '0;

endmodule
